// File: rtl/table_pkg.sv
// Shared types, default sizing and helpers for the multi-port register table.
package table_pkg;

  typedef enum logic {ST_IDLE, ST_CLEAR} tbl_state_e;

  localparam int unsigned TBL_DEPTH      = 32;
  localparam int unsigned TBL_DATA_WIDTH = 8;
  localparam int unsigned TBL_WR_PORTS   = 2;
  localparam int unsigned TBL_RD_PORTS   = 2;

  function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/table_wr_arbiter.sv
// Per-entry write winner select over all write ports, plus same-index collision detect.
module table_wr_arbiter #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WR_PORTS   = 2,
  parameter int unsigned IDX_W      = 5
) (
  input  logic                                 wr_block,
  input  logic [WR_PORTS-1:0]                  wr_en,
  input  logic [WR_PORTS*IDX_W-1:0]            index_wr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0]       data_wr,
  output logic [DEPTH-1:0]                     we,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0]     wdata,
  output logic                                 conflict
);

  // Ascending port scan: later (higher) ports overwrite earlier hits, so the highest port wins.
  // Only indices below DEPTH can ever match an entry, so dropped writes never flag a conflict.
  always_comb begin
    we       = '0;
    wdata    = '0;
    conflict = 1'b0;
    if (!wr_block) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        for (int unsigned p = 0; p < WR_PORTS; p++) begin
          if (wr_en[p] && (index_wr[p*IDX_W +: IDX_W] == IDX_W'(e))) begin
            if (we[e]) conflict = 1'b1;
            we[e]    = 1'b1;
            wdata[e] = data_wr[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: rtl/multi_port_table.sv
// Multi-port flop register table with registered reads and a sequential clear sweep.
// Define TABLE_BYPASS_EN for write-first forwarding of same-cycle writes to reads.
module multi_port_table
  import table_pkg::*;
#(
  parameter int unsigned DEPTH       = TBL_DEPTH,
  parameter int unsigned DATA_WIDTH  = TBL_DATA_WIDTH,
  parameter int unsigned WR_PORTS    = TBL_WR_PORTS,
  parameter int unsigned RD_PORTS    = TBL_RD_PORTS,
  parameter int unsigned IDX_W       = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*IDX_W-1:0]      index_wr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] data_wr,
  input  logic [RD_PORTS-1:0]            rd_en,
  input  logic [RD_PORTS*IDX_W-1:0]      index_rd,
  output logic [RD_PORTS*DATA_WIDTH-1:0] data_rd,
  output logic [RD_PORTS-1:0]            rd_valid,
  input  logic                           clear_req,
  output logic                           busy,
  output logic                           wr_conflict
);

  tbl_state_e                        state_q, state_d;
  logic [IDX_W-1:0]                  ptr_q, ptr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_q, mem_d;
  logic [RD_PORTS*DATA_WIDTH-1:0]    data_rd_q, data_rd_d;
  logic [RD_PORTS-1:0]               rd_valid_q, rd_valid_d;
  logic                              wr_conflict_q, wr_conflict_d;

  logic                              wr_block;
  logic [DEPTH-1:0]                  we;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  wdata;
  logic                              conflict;

  // The clear_req cycle itself also drops writes.
  assign wr_block = (state_q == ST_CLEAR) || clear_req;

  table_wr_arbiter #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WR_PORTS   (WR_PORTS),
    .IDX_W      (IDX_W)
  ) u_wr_arbiter (
    .wr_block (wr_block),
    .wr_en    (wr_en),
    .index_wr (index_wr),
    .data_wr  (data_wr),
    .we       (we),
    .wdata    (wdata),
    .conflict (conflict)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) mem_d[ptr_q] = RESET_VALUE;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (we[e]) mem_d[e] = wdata[e];
    end
  end

  always_comb begin
    data_rd_d     = data_rd_q;
    rd_valid_d    = rd_en;
    wr_conflict_d = conflict;
    for (int unsigned r = 0; r < RD_PORTS; r++) begin
      if (rd_en[r]) begin
        if (idx_in_range(32'(index_rd[r*IDX_W +: IDX_W]), DEPTH)) begin
`ifdef TABLE_BYPASS_EN
          data_rd_d[r*DATA_WIDTH +: DATA_WIDTH] = we[index_rd[r*IDX_W +: IDX_W]]
                                                ? wdata[index_rd[r*IDX_W +: IDX_W]]
                                                : mem_q[index_rd[r*IDX_W +: IDX_W]];
`else
          data_rd_d[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[index_rd[r*IDX_W +: IDX_W]];
`endif
        end else begin
          data_rd_d[r*DATA_WIDTH +: DATA_WIDTH] = RESET_VALUE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      mem_q         <= {DEPTH{RESET_VALUE}};
      data_rd_q     <= '0;
      rd_valid_q    <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      mem_q         <= mem_d;
      data_rd_q     <= data_rd_d;
      rd_valid_q    <= rd_valid_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign data_rd     = data_rd_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = (state_q == ST_CLEAR);
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_multi_port_table.sv
// Scoreboard bench for multi_port_table: random stimulus against an array model, plus a DEPTH=20 instance.
module tb_multi_port_table;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  wr_en, rd_en;
  logic [9:0]  index_wr, index_rd;
  logic [15:0] data_wr, data_rd;
  logic [1:0]  rd_valid;
  logic        clear_req, busy, wr_conflict;

  logic [1:0]  wr_en_s, rd_en_s;
  logic [9:0]  index_wr_s, index_rd_s;
  logic [15:0] data_wr_s, data_rd_s;
  logic [1:0]  rd_valid_s;
  logic        busy_s, wr_conflict_s;

  multi_port_table u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .index_wr(index_wr), .data_wr(data_wr),
    .rd_en(rd_en), .index_rd(index_rd), .data_rd(data_rd), .rd_valid(rd_valid),
    .clear_req(clear_req), .busy(busy), .wr_conflict(wr_conflict)
  );

  multi_port_table #(.DEPTH(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_s), .index_wr(index_wr_s), .data_wr(data_wr_s),
    .rd_en(rd_en_s), .index_rd(index_rd_s), .data_rd(data_rd_s), .rd_valid(rd_valid_s),
    .clear_req(1'b0), .busy(busy_s), .wr_conflict(wr_conflict_s)
  );

  typedef struct {
    int         tag;
    logic [1:0] rv;
    logic       conf;
    logic       busy;
  } cyc_t;

  cyc_t       cyc_q[$];
  logic [7:0] rdq0[$], rdq1[$];
  logic [7:0] mdl[DEPTH];
  int         busy_left;
  int         edge_cnt = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: rd_valid high with no read outstanding (t=%0t)", nm, $time);
  endtask

  // Monitor: per-edge status from the cycle queue, read data popped whenever rd_valid shows.
  cyc_t ce;
  always @(negedge clk) begin
    if (rst_n) begin
      while (cyc_q.size() > 0 && cyc_q[0].tag <= edge_cnt) begin
        ce = cyc_q.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'(ce.rv));
        chk("wr_conflict", 32'(wr_conflict), 32'(ce.conf));
        chk("busy", 32'(busy), 32'(ce.busy));
      end
      if (rd_valid[0]) begin
        if (rdq0.size() == 0) unexpected("data_rd0");
        else chk("data_rd0", 32'(data_rd[7:0]), 32'(rdq0.pop_front()));
      end
      if (rd_valid[1]) begin
        if (rdq1.size() == 0) unexpected("data_rd1");
        else chk("data_rd1", 32'(data_rd[15:8]), 32'(rdq1.pop_front()));
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    busy_left = 0;
  endtask

  // One clock of stimulus; the model predicts the table's response at the coming edge.
  task automatic step(input logic [1:0] we, input int wi0, input int wi1,
                      input logic [7:0] wd0, input logic [7:0] wd1,
                      input logic [1:0] re, input int ri0, input int ri1, input bit clr);
    int         wi[2];
    int         ri[2];
    logic [7:0] wd[2];
    logic [7:0] v;
    bit         blocked;
    cyc_t       e;
    wi[0] = wi0; wi[1] = wi1; wd[0] = wd0; wd[1] = wd1; ri[0] = ri0; ri[1] = ri1;
    blocked = (busy_left > 0) || clr;
    for (int r = 0; r < 2; r++) begin
      if (re[r]) begin
        v = mdl[ri[r]];
`ifdef TABLE_BYPASS_EN
        for (int p = 0; p < 2; p++)
          if (!blocked && we[p] && wi[p] == ri[r]) v = wd[p];
`endif
        if (r == 0) rdq0.push_back(v);
        else        rdq1.push_back(v);
      end
    end
    e.conf = !blocked && (we == 2'b11) && (wi0 == wi1);
    if (busy_left > 0) begin
      mdl[DEPTH - busy_left] = 8'h00;
      busy_left--;
    end else if (clr) begin
      busy_left = DEPTH;
    end else begin
      for (int p = 0; p < 2; p++) if (we[p]) mdl[wi[p]] = wd[p];
    end
    e.tag  = edge_cnt + 1;
    e.rv   = re;
    e.busy = busy_left > 0;
    cyc_q.push_back(e);
    wr_en     = we;
    index_wr  = {5'(wi1), 5'(wi0)};
    data_wr   = {wd1, wd0};
    rd_en     = re;
    index_rd  = {5'(ri1), 5'(ri0)};
    clear_req = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0, 1'b0);
  endtask

  task automatic rand_step(input bit allow_clr);
    int a, b;
    a = int'($urandom_range(0, 31));
    b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 31));
    step(2'($urandom_range(0, 3)), a, b, 8'($urandom), 8'($urandom),
         2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
         allow_clr && ($urandom_range(0, 39) == 0));
  endtask

  task automatic fill_table();
    for (int i = 0; i < DEPTH / 2; i++)
      step(2'b11, 2*i, 2*i + 1, 8'($urandom), 8'($urandom), 2'b00, 0, 0, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(2'b00, 0, 0, 8'h00, 8'h00, 2'b11, i, DEPTH - 1 - i, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_conflict", 32'(wr_conflict), 32'd0);
    chk("rst_data_rd", 32'(data_rd), 32'd0);
    model_reset();
    wr_en = '0; rd_en = '0; clear_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_en = '0; index_wr = '0; data_wr = '0; rd_en = '0; index_rd = '0; clear_req = 1'b0;
    wr_en_s = '0; index_wr_s = '0; data_wr_s = '0; rd_en_s = '0; index_rd_s = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data_rd", 32'(data_rd), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_conflict", 32'(wr_conflict), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    read_all();

    // Collision on idx 5, then distinct indices.
    step(2'b11, 5, 5, 8'hAA, 8'h55, 2'b00, 0, 0, 1'b0);
    idle_step();
    step(2'b00, 0, 0, 8'h00, 8'h00, 2'b11, 5, 5, 1'b0);
    step(2'b11, 7, 9, 8'h11, 8'h22, 2'b00, 0, 0, 1'b0);
    step(2'b00, 0, 0, 8'h00, 8'h00, 2'b11, 7, 9, 1'b0);

    // Same-cycle write and read of idx 3.
    step(2'b01, 3, 0, 8'h3C, 8'h00, 2'b01, 3, 0, 1'b0);
    step(2'b00, 0, 0, 8'h00, 8'h00, 2'b01, 3, 0, 1'b0);

    // Clear sweep with writes in the request cycle and during the sweep, plus an ignored re-request.
    fill_table();
    step(2'b11, 0, 1, 8'hF0, 8'h0F, 2'b11, 0, 31, 1'b1);
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (i == 10) step(2'b11, 20, 21, 8'h99, 8'h98, 2'b11, 20, 31, 1'b1);
      else         rand_step(1'b0);
    end
    read_all();

    // Reset in the middle of a sweep, then a fresh sweep from entry 0.
    fill_table();
    step(2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0, 1'b1);
    repeat (10) rand_step(1'b0);
    do_reset();
    read_all();
    fill_table();
    step(2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 0, 0, 1'b1);
    repeat (DEPTH + 2) rand_step(1'b0);
    read_all();

    repeat (300) rand_step(1'b1);
    repeat (DEPTH + 2) idle_step();

    // DEPTH=20 instance: out-of-range writes dropped, reads of them give the reset value.
    wr_en_s = 2'b11; index_wr_s = {5'd25, 5'd25}; data_wr_s = 16'h8877;
    rd_en_s = 2'b11; index_rd_s = {5'd4, 5'd25};
    @(posedge clk); #1;
    chk("d20_rd_valid", 32'(rd_valid_s), 32'd3);
    chk("d20_rd25_first", 32'(data_rd_s[7:0]), 32'd0);
    chk("d20_rd4_first", 32'(data_rd_s[15:8]), 32'd0);
    chk("d20_conflict_oor", 32'(wr_conflict_s), 32'd0);
    wr_en_s = 2'b11; index_wr_s = {5'd19, 5'd4}; data_wr_s = 16'hC35A; rd_en_s = 2'b00;
    @(posedge clk); #1;
    chk("d20_rd_valid_off", 32'(rd_valid_s), 32'd0);
    chk("d20_conflict_distinct", 32'(wr_conflict_s), 32'd0);
    wr_en_s = 2'b00; rd_en_s = 2'b11; index_rd_s = {5'd4, 5'd25};
    @(posedge clk); #1;
    chk("d20_rd25", 32'(data_rd_s[7:0]), 32'd0);
    chk("d20_rd4", 32'(data_rd_s[15:8]), 32'h5A);
    index_rd_s = {5'd20, 5'd19};
    @(posedge clk); #1;
    chk("d20_rd19", 32'(data_rd_s[7:0]), 32'hC3);
    chk("d20_rd20", 32'(data_rd_s[15:8]), 32'd0);
    rd_en_s = 2'b00;
    @(posedge clk); #1;

    chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    chk("rdq0_drained", 32'(rdq0.size()), 32'd0);
    chk("rdq1_drained", 32'(rdq1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
